// File: rtl/cic_sample_fifo.sv
// Sample buffer behind the cic decimator: captures one word per rising edge of the
// decimated clock and hands words to the readout stage over valid/ready.
module cic_sample_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_s_clk,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [ADDR_BITS:0]    o_level,
  output logic                  o_overflow,
  input  logic                  i_clr_ovf
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] FULL_LEVEL = DEPTH[ADDR_BITS:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_BITS:0]    wr_ptr;
  logic [ADDR_BITS:0]    rd_ptr;
  logic                  s_clk_d;

  logic s_edge;
  logic wr_req;
  logic rd;
  logic full;
  logic wr_ok;
  logic drop;

  assign s_edge  = i_s_clk & ~s_clk_d;
  assign wr_req  = s_edge & i_en;
  assign o_level = wr_ptr - rd_ptr;
  assign o_valid = (o_level != '0);
  assign rd      = o_valid & i_ready;
  assign full    = (o_level == FULL_LEVEL);
  // A full FIFO still accepts a write when the head is popped in the same cycle.
  assign wr_ok   = wr_req & (~full | rd);
  assign drop    = wr_req & full & ~rd;

  // Gate the head so the output reads zero while empty (including out of reset).
  assign o_data  = o_valid ? mem[rd_ptr[ADDR_BITS-1:0]] : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s_clk_d    <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_overflow <= 1'b0;
    end else begin
      s_clk_d <= i_s_clk;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd)    rd_ptr <= rd_ptr + 1'b1;
      if (drop)
        o_overflow <= 1'b1;
      else if (i_clr_ovf)
        o_overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wr_ptr[ADDR_BITS-1:0]] <= i_data;
  end

endmodule

// File: tb/tb_cic_sample_fifo.sv
// Scoreboard bench for cic_sample_fifo: writes push expected words, a negedge
// monitor pops and compares every accepted head word.
module tb_cic_sample_fifo;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       s_clk;
  logic [7:0] din;
  logic [7:0] dout;
  logic       valid;
  logic       ready;
  logic [3:0] level;
  logic       ovf;
  logic       clr_ovf;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  logic in_stream = 1'b0;
  logic level_exceeded = 1'b0;
  int stream_pops = 0;

  cic_sample_fifo #(.DATA_WIDTH(8), .ADDR_BITS(3)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_s_clk(s_clk), .i_data(din),
    .o_data(dout), .o_valid(valid), .i_ready(ready), .o_level(level),
    .o_overflow(ovf), .i_clr_ovf(clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pop_unexpected: got %h, expected no word", dout);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          miscompares++;
          $display("FAIL pop_data: got %h, expected %h", dout, e);
        end
        if (in_stream) stream_pops++;
      end
    end
    if (in_stream && level > 4'd1) level_exceeded = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Rising edge on s_clk with data; the write lands on the following clock edge.
  task automatic pulse(input logic [7:0] d, input bit expect_store);
    din = d;
    s_clk = 1'b1;
    if (expect_store) exp_q.push_back(d);
    tick();
    s_clk = 1'b0;
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    ready = 1'b1;
    while (valid && n < 20) begin
      tick();
      n++;
    end
    ready = 1'b0;
    chk("drain_done", {31'd0, valid}, 32'd0);
  endtask

  initial begin
    logic [15:0] lfsr;
    logic [7:0]  acc;
    logic [7:0]  golden;

    rst_n = 1'b0; en = 1'b1; s_clk = 1'b1; din = 8'h00; ready = 1'b0; clr_ovf = 1'b0;
    #1;
    chk("reset_level", {28'd0, level}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_data", {24'd0, dout}, 32'd0);
    chk("reset_ovf", {31'd0, ovf}, 32'd0);
    tick(); tick();

    // 1: s_clk already high at reset release must not write
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("t1_level", {28'd0, level}, 32'd0);
    chk("t1_valid", {31'd0, valid}, 32'd0);
    s_clk = 1'b0;
    tick();

    // 2: single word, visible one cycle after the edge cycle
    din = 8'hA5;
    s_clk = 1'b1;
    exp_q.push_back(8'hA5);
    chk("t2_valid_edge_cycle", {31'd0, valid}, 32'd0);
    tick();
    s_clk = 1'b0;
    chk("t2_valid", {31'd0, valid}, 32'd1);
    chk("t2_data", {24'd0, dout}, 32'hA5);
    chk("t2_level", {28'd0, level}, 32'd1);
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("t2_level_after_pop", {28'd0, level}, 32'd0);
    chk("t2_valid_after_pop", {31'd0, valid}, 32'd0);

    // enable low: edge tracked but no write; re-enable while high gives no write
    en = 1'b0;
    din = 8'h77;
    s_clk = 1'b1;
    tick(); tick();
    en = 1'b1;
    tick(); tick();
    chk("en_suppress_level", {28'd0, level}, 32'd0);
    s_clk = 1'b0;
    tick();

    // 3: fill to eight, ninth is dropped
    for (int i = 1; i <= 8; i++) pulse(8'(i), 1'b1);
    chk("t3_full_level", {28'd0, level}, 32'd8);
    chk("t3_no_ovf", {31'd0, ovf}, 32'd0);
    pulse(8'h09, 1'b0);
    chk("t3_drop_level", {28'd0, level}, 32'd8);
    chk("t3_drop_ovf", {31'd0, ovf}, 32'd1);

    // 4: full with simultaneous write and pop
    din = 8'hAA;
    s_clk = 1'b1;
    ready = 1'b1;
    exp_q.push_back(8'hAA);
    tick();
    ready = 1'b0;
    s_clk = 1'b0;
    chk("t4_level", {28'd0, level}, 32'd8);
    chk("t4_ovf", {31'd0, ovf}, 32'd1);
    tick();

    // 5: clear coincident with a drop keeps the flag; quiet clear removes it
    din = 8'hBB;
    s_clk = 1'b1;
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    s_clk = 1'b0;
    chk("t5_set_wins", {31'd0, ovf}, 32'd1);
    chk("t5_level", {28'd0, level}, 32'd8);
    tick();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t5_cleared", {31'd0, ovf}, 32'd0);

    drain();
    chk("t5_queue_empty", exp_q.size(), 32'd0);

    // 6: order-1 decimate-by-64 stream of a 1-bit input is a 64-sample window sum
    lfsr = 16'hACE1;
    acc = 8'd0;
    golden = 8'd0;
    ready = 1'b1;
    in_stream = 1'b1;
    for (int n = 0; n < 21; n++) begin
      for (int c = 0; c < 64; c++) begin
        if (c == 0) begin
          din = golden;
          if (n > 0) begin
            s_clk = 1'b1;
            exp_q.push_back(golden);
          end
        end
        if (c == 32) s_clk = 1'b0;
        acc = acc + {7'd0, lfsr[0]};
        lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        tick();
      end
      golden = acc;
      acc = 8'd0;
    end
    tick(); tick();
    in_stream = 1'b0;
    ready = 1'b0;
    chk("t6_pop_count", stream_pops, 32'd20);
    chk("t6_level_max1", {31'd0, level_exceeded}, 32'd0);
    chk("t6_queue_empty", exp_q.size(), 32'd0);
    chk("t6_ovf", {31'd0, ovf}, 32'd0);

    // mid-operation reset discards contents asynchronously
    pulse(8'h3C, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", {31'd0, valid}, 32'd0);
    chk("async_reset_level", {28'd0, level}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
